// File: rtl/vga_pkg.sv
// Shared definitions for the VGA dither output stage: the 4x4 Bayer matrix,
// sync polarity encodings and the 6-bit to 2-bit dithering quantiser.
package vga_pkg;

  localparam int unsigned SYNC_ACTIVE_LOW  = 0;
  localparam int unsigned SYNC_ACTIVE_HIGH = 1;

  localparam logic [3:0] BAYER [0:3][0:3] = '{
    '{4'd0,  4'd8,  4'd2,  4'd10},
    '{4'd12, 4'd4,  4'd14, 4'd6 },
    '{4'd3,  4'd11, 4'd1,  4'd9 },
    '{4'd15, 4'd7,  4'd13, 4'd5 }
  };

  // Idle (inactive) level of hsync/vsync for a given polarity setting.
  function automatic logic sync_idle_level(input int unsigned pol);
    return (pol == SYNC_ACTIVE_LOW);
  endfunction

  // Round the top two bits up when the fraction strictly exceeds the threshold;
  // full scale saturates so the result never wraps.
  function automatic logic [1:0] quant2(input logic [5:0] v, input logic [3:0] t);
    if (v[5:4] == 2'd3) begin
      return 2'd3;
    end
    return v[5:4] + {1'b0, (v[3:0] > t)};
  endfunction

endpackage

// File: rtl/bayer_quant.sv
// Combinational per-channel quantiser: Bayer-threshold rounding when DITHER=1,
// plain truncation to the top two bits when DITHER=0.
module bayer_quant
  import vga_pkg::*;
#(
  parameter int unsigned DITHER = 1
) (
  input  logic [5:0] v,
  input  logic [3:0] t,
  output logic [1:0] q
);

  generate
    if (DITHER != 0) begin : g_dither
      assign q = quant2(v, t);
    end else begin : g_trunc
      assign q = v[5:4];
    end
  endgenerate

endmodule

// File: rtl/vga_dither_out.sv
// Final VGA pixel stage: 4x4 ordered dither of 6-bit RGB down to RRGGBB with
// syncs delayed to match. Build with VGA_DITHER_TEMPORAL_EN to rotate the
// dither pattern every frame.
module vga_dither_out
  import vga_pkg::*;
#(
  parameter int unsigned SYNC_POL = 0,
  parameter int unsigned DITHER   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] r_in,
  input  logic [5:0] g_in,
  input  logic [5:0] b_in,
  input  logic       de_in,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic [1:0] r_out,
  output logic [1:0] g_out,
  output logic [1:0] b_out,
  output logic       hsync_out,
  output logic       vsync_out
);

  localparam logic SYNC_IDLE = sync_idle_level(SYNC_POL);

  logic vs_act_in;
  logic vs_rise;
  logic de_fall;

  logic [1:0] x_q, x_d;
  logic [1:0] y_q, y_d;
  logic       de_prev_q, de_prev_d;
  logic       vs_prev_q, vs_prev_d;

  logic [1:0] tx, ty;

  // Stage 1: registered pixel, timing and threshold.
  logic [5:0] r1_q, r1_d, g1_q, g1_d, b1_q, b1_d;
  logic       de1_q, de1_d, hs1_q, hs1_d, vs1_q, vs1_d;
  logic [3:0] t1_q, t1_d;

  // Stage 2: registered output.
  logic [1:0] r2_q, r2_d, g2_q, g2_d, b2_q, b2_d;
  logic       hs2_q, hs2_d, vs2_q, vs2_d;
  logic [1:0] rq, gq, bq;

  assign vs_act_in = (vsync_in != SYNC_IDLE);
  assign vs_rise   = vs_act_in && !vs_prev_q;
  assign de_fall   = de_prev_q && !de_in;

  always_comb begin
    x_d       = de_in ? (x_q + 2'd1) : 2'd0;
    y_d       = y_q;
    // A frame start overrides a line end landing on the same cycle.
    if (vs_rise) begin
      y_d = 2'd0;
    end else if (de_fall) begin
      y_d = y_q + 2'd1;
    end
    de_prev_d = de_in;
    vs_prev_d = vs_act_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q       <= 2'd0;
      y_q       <= 2'd0;
      de_prev_q <= 1'b0;
      vs_prev_q <= 1'b0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      de_prev_q <= de_prev_d;
      vs_prev_q <= vs_prev_d;
    end
  end

`ifdef VGA_DITHER_TEMPORAL_EN
  logic [1:0] f_q, f_d;

  always_comb begin
    f_d = vs_rise ? (f_q + 2'd1) : f_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      f_q <= 2'd0;
    end else begin
      f_q <= f_d;
    end
  end

  assign tx = x_q + {1'b0, f_q[0]};
  assign ty = y_q + {1'b0, f_q[1]};
`else
  assign tx = x_q;
  assign ty = y_q;
`endif

  always_comb begin
    r1_d  = r_in;
    g1_d  = g_in;
    b1_d  = b_in;
    de1_d = de_in;
    hs1_d = hsync_in;
    vs1_d = vsync_in;
    t1_d  = BAYER[ty][tx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r1_q  <= 6'd0;
      g1_q  <= 6'd0;
      b1_q  <= 6'd0;
      de1_q <= 1'b0;
      hs1_q <= SYNC_IDLE;
      vs1_q <= SYNC_IDLE;
      t1_q  <= 4'd0;
    end else begin
      r1_q  <= r1_d;
      g1_q  <= g1_d;
      b1_q  <= b1_d;
      de1_q <= de1_d;
      hs1_q <= hs1_d;
      vs1_q <= vs1_d;
      t1_q  <= t1_d;
    end
  end

  bayer_quant #(.DITHER(DITHER)) u_quant_r (.v(r1_q), .t(t1_q), .q(rq));
  bayer_quant #(.DITHER(DITHER)) u_quant_g (.v(g1_q), .t(t1_q), .q(gq));
  bayer_quant #(.DITHER(DITHER)) u_quant_b (.v(b1_q), .t(t1_q), .q(bq));

  // Blanking forces black so palette garbage never leaks into the porches.
  always_comb begin
    r2_d  = de1_q ? rq : 2'd0;
    g2_d  = de1_q ? gq : 2'd0;
    b2_d  = de1_q ? bq : 2'd0;
    hs2_d = hs1_q;
    vs2_d = vs1_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r2_q  <= 2'd0;
      g2_q  <= 2'd0;
      b2_q  <= 2'd0;
      hs2_q <= SYNC_IDLE;
      vs2_q <= SYNC_IDLE;
    end else begin
      r2_q  <= r2_d;
      g2_q  <= g2_d;
      b2_q  <= b2_d;
      hs2_q <= hs2_d;
      vs2_q <= vs2_d;
    end
  end

  assign r_out     = r2_q;
  assign g_out     = g2_q;
  assign b_out     = b2_q;
  assign hsync_out = hs2_q;
  assign vsync_out = vs2_q;

endmodule

// File: tb/tb_vga_dither_out.sv
// Bench for vga_dither_out: active-low, active-high and truncating instances
// share one stimulus stream; expected outputs are queued and checked on arrival.
module tb_vga_dither_out;

  typedef struct packed {
    int unsigned due;
    logic [1:0]  r, g, b;
    logic [1:0]  tr, tg, tb;
    logic        hs, vs;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] r_in, g_in, b_in;
  logic       de_in, hs_act, vs_act;
  logic       hs_lo, vs_lo, hs_hi, vs_hi;

  logic [1:0] r0, g0, b0, r1, g1, b1, rt, gt, bt;
  logic       hs0, vs0, hs1, vs1, hst, vst;

  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;
  exp_t        exp_q[$];
  exp_t        mon_e;

  assign hs_lo = ~hs_act;
  assign vs_lo = ~vs_act;
  assign hs_hi = hs_act;
  assign vs_hi = vs_act;

  vga_dither_out #(.SYNC_POL(0), .DITHER(1)) u_pol0 (
    .clk(clk), .reset(reset), .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .de_in(de_in), .hsync_in(hs_lo), .vsync_in(vs_lo),
    .r_out(r0), .g_out(g0), .b_out(b0), .hsync_out(hs0), .vsync_out(vs0)
  );

  vga_dither_out #(.SYNC_POL(1), .DITHER(1)) u_pol1 (
    .clk(clk), .reset(reset), .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .de_in(de_in), .hsync_in(hs_hi), .vsync_in(vs_hi),
    .r_out(r1), .g_out(g1), .b_out(b1), .hsync_out(hs1), .vsync_out(vs1)
  );

  vga_dither_out #(.SYNC_POL(0), .DITHER(0)) u_trunc (
    .clk(clk), .reset(reset), .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .de_in(de_in), .hsync_in(hs_lo), .vsync_in(vs_lo),
    .r_out(rt), .g_out(gt), .b_out(bt), .hsync_out(hst), .vsync_out(vst)
  );

  // Clock and cycle count.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] e4(input logic [1:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  // Driver: one pixel cycle; its result is due two edges later.
  task automatic pix(input logic [5:0] r, g, b, input logic de, hs, vs,
                     input logic [1:0] er, eg, eb);
    exp_t e;
    @(negedge clk);
    reset = 1'b0;
    r_in = r; g_in = g; b_in = b;
    de_in = de; hs_act = hs; vs_act = vs;
    e.due = cyc + 2;
    e.r = er; e.g = eg; e.b = eb;
    e.tr = de ? r[5:4] : 2'd0;
    e.tg = de ? g[5:4] : 2'd0;
    e.tb = de ? b[5:4] : 2'd0;
    e.hs = hs; e.vs = vs;
    exp_q.push_back(e);
  endtask

  // Driver: one reset cycle; outputs go idle on the next edge and the
  // following one, discarding whatever was still in flight.
  task automatic rst_cyc(input logic [5:0] rgb, input logic de);
    exp_t e;
    @(negedge clk);
    reset = 1'b1;
    r_in = rgb; g_in = rgb; b_in = rgb;
    de_in = de; hs_act = 1'b0; vs_act = 1'b0;
    while (exp_q.size() > 0 && exp_q[$].due >= cyc + 1) void'(exp_q.pop_back());
    e = '0;
    e.due = cyc + 1;
    exp_q.push_back(e);
    e.due = cyc + 2;
    exp_q.push_back(e);
  endtask

  task automatic blank(input int n, input logic hs, vs);
    for (int i = 0; i < n; i++) pix(6'h3F, 6'h3F, 6'h3F, 1'b0, hs, vs, 2'd0, 2'd0, 2'd0);
  endtask

  task automatic line(input logic [5:0] r, g, b, input logic [7:0] er, eg, eb);
    for (int i = 0; i < 4; i++) pix(r, g, b, 1'b1, 1'b0, 1'b0, er[2*i +: 2], eg[2*i +: 2], eb[2*i +: 2]);
  endtask

  task automatic hs_gap();
    blank(2, 1'b1, 1'b0);
    blank(1, 1'b0, 1'b0);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, act, req);
    end
  endtask

  // Scoreboard monitor: compare each queued entry on its due cycle.
  initial begin
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        mon_e = exp_q.pop_front();
        if (mon_e.due != cyc) begin
          checks++;
          failures++;
          $display("FAIL late_entry cyc=%0d got=none want=due%0d", cyc, mon_e.due);
        end else begin
          check("pol0", {r0, g0, b0, hs0, vs0}, {mon_e.r, mon_e.g, mon_e.b, ~mon_e.hs, ~mon_e.vs});
          check("pol1", {r1, g1, b1, hs1, vs1}, {mon_e.r, mon_e.g, mon_e.b, mon_e.hs, mon_e.vs});
          check("trunc", {rt, gt, bt, hst, vst}, {mon_e.tr, mon_e.tg, mon_e.tb, ~mon_e.hs, ~mon_e.vs});
        end
      end
    end
  end

  initial begin
    int wait_cyc;
    reset = 1'b1;
    r_in = '0; g_in = '0; b_in = '0;
    de_in = 1'b0; hs_act = 1'b0; vs_act = 1'b0;

    repeat (3) rst_cyc(6'h00, 1'b0);
    blank(2, 1'b0, 1'b0);

    // Two pixels of a row-0 line, then reset hits mid-line.
    pix(6'h18, 6'h3F, 6'h00, 1'b1, 1'b0, 1'b0, 2'd2, 2'd3, 2'd0);
    pix(6'h18, 6'h3F, 6'h00, 1'b1, 1'b0, 1'b0, 2'd1, 2'd3, 2'd0);
    repeat (3) rst_cyc(6'h3F, 1'b1);

    // y=0, T = 0 8 2 10
    line(6'h18, 6'h3F, 6'h00, e4(2, 1, 2, 1), e4(3, 3, 3, 3), e4(0, 0, 0, 0));
    hs_gap();
    // y=1, T = 12 4 14 6
    line(6'h20, 6'h18, 6'h3F, e4(2, 2, 2, 2), e4(1, 2, 1, 2), e4(3, 3, 3, 3));
    hs_gap();
    // y=2, T = 3 11 1 9
    line(6'h3F, 6'h18, 6'h00, e4(3, 3, 3, 3), e4(2, 1, 2, 1), e4(0, 0, 0, 0));
    hs_gap();
    // y=3, T = 15 7 13 5
    line(6'h18, 6'h00, 6'h20, e4(1, 2, 1, 2), e4(0, 0, 0, 0), e4(2, 2, 2, 2));
    hs_gap();
    // y wraps to 0
    line(6'h00, 6'h18, 6'h27, e4(0, 0, 0, 0), e4(2, 1, 2, 1), e4(3, 2, 3, 2));
    hs_gap();
    // y=1 and y=2, then line end and vsync start on the same cycle.
    line(6'h20, 6'h3F, 6'h00, e4(2, 2, 2, 2), e4(3, 3, 3, 3), e4(0, 0, 0, 0));
    hs_gap();
    line(6'h20, 6'h3F, 6'h00, e4(2, 2, 2, 2), e4(3, 3, 3, 3), e4(0, 0, 0, 0));
    pix(6'h3F, 6'h3F, 6'h3F, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 2'd0);
    blank(1, 1'b0, 1'b1);
    blank(2, 1'b0, 1'b0);

    // New frame, y=0. Rotated pattern in frame 1 gives T = 8 2 10 0.
`ifdef VGA_DITHER_TEMPORAL_EN
    line(6'h18, 6'h18, 6'h18, e4(1, 2, 1, 2), e4(1, 2, 1, 2), e4(1, 2, 1, 2));
`else
    line(6'h18, 6'h18, 6'h18, e4(2, 1, 2, 1), e4(2, 1, 2, 1), e4(2, 1, 2, 1));
`endif
    hs_gap();
    // y=1: fraction 15 beats every threshold in this row.
    line(6'h2F, 6'h2F, 6'h2F, e4(3, 3, 3, 3), e4(3, 3, 3, 3), e4(3, 3, 3, 3));
    blank(3, 1'b0, 1'b0);

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain got=%0d_pending want=0_pending", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
